// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes the D-stage instruction, resolves operands and detects load-use hazards into the E register.
// Optional feature macro ALU_ISSUE_FORWARDING_EN: E/M/W forwarding; when undefined, dependants stall until written back.
module alu_issue_stage #(
  parameter int WORD_SIZE = 32,
  parameter int REG_ADDR  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 validD,
  input  logic [3:0]           opD,
  input  logic [REG_ADDR-1:0]  rs1D,
  input  logic [REG_ADDR-1:0]  rs2D,
  input  logic [REG_ADDR-1:0]  rdD,
  input  logic [WORD_SIZE-1:0] rd1D,
  input  logic [WORD_SIZE-1:0] rd2D,
  input  logic [WORD_SIZE-1:0] immD,
  input  logic [WORD_SIZE-1:0] aluOutE,
  input  logic                 regWriteM,
  input  logic [REG_ADDR-1:0]  rdM,
  input  logic [WORD_SIZE-1:0] aluOutM,
  input  logic                 regWriteW,
  input  logic [REG_ADDR-1:0]  rdW,
  input  logic [WORD_SIZE-1:0] resultW,
  input  logic                 stallE,
  input  logic                 flushE,
  output logic [WORD_SIZE-1:0] srcAE,
  output logic [WORD_SIZE-1:0] srcBE,
  output logic [2:0]           ALUControlE,
  output logic [REG_ADDR-1:0]  rdE,
  output logic                 regWriteE,
  output logic                 memReadE,
  output logic                 validE,
  output logic                 illegalE,
  output logic                 stallD
);

  typedef enum logic [2:0] {
    AND_OP = 3'b000,
    OR_OP  = 3'b001,
    ADD_OP = 3'b010,
    MUL_OP = 3'b011,
    SUB_OP = 3'b110
  } alu_op_t;

  alu_op_t alu_ctrl;
  logic    legal;
  logic    use_imm;
  logic    is_load;
  logic    uses_a;
  logic    uses_b;

  always_comb begin
    alu_ctrl = ADD_OP;
    legal    = 1'b1;
    use_imm  = 1'b0;
    is_load  = 1'b0;
    case (opD)
      4'd0: alu_ctrl = ADD_OP;
      4'd1: alu_ctrl = SUB_OP;
      4'd2: alu_ctrl = MUL_OP;
      4'd3: alu_ctrl = AND_OP;
      4'd4: alu_ctrl = OR_OP;
      4'd5: use_imm = 1'b1;
      4'd6: begin
        use_imm = 1'b1;
        is_load = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Immediate forms never read rs2, and illegal opcodes read nothing, so neither can raise a hazard.
  assign uses_a = validD & legal;
  assign uses_b = validD & legal & ~use_imm;

  logic a_zero;
  logic b_zero;
  logic load_use;
  logic raw_wait;
  logic hazard;
  logic [WORD_SIZE-1:0] op_a;
  logic [WORD_SIZE-1:0] op_b;

  assign a_zero = (rs1D == '0);
  assign b_zero = (rs2D == '0);

  assign load_use = validE & memReadE & (rdE != '0) &
                    ((uses_a & (rdE == rs1D)) | (uses_b & (rdE == rs2D)));

`ifdef ALU_ISSUE_FORWARDING_EN
  logic fwd_e_ok;

  // A load in E has no data yet, so it is never a forwarding source.
  assign fwd_e_ok = validE & regWriteE & ~memReadE;

  always_comb begin
    op_a = rd1D;
    if (a_zero)
      op_a = '0;
    else if (fwd_e_ok && (rdE == rs1D))
      op_a = aluOutE;
    else if (regWriteM && (rdM == rs1D))
      op_a = aluOutM;
    else if (regWriteW && (rdW == rs1D))
      op_a = resultW;

    op_b = rd2D;
    if (b_zero)
      op_b = '0;
    else if (fwd_e_ok && (rdE == rs2D))
      op_b = aluOutE;
    else if (regWriteM && (rdM == rs2D))
      op_b = aluOutM;
    else if (regWriteW && (rdW == rs2D))
      op_b = resultW;
  end

  assign raw_wait = 1'b0;
`else
  logic wr_e;
  logic unused_fwd;

  assign wr_e = validE & regWriteE;

  // Without forwarding, wait until the producer has left W; the write-first register file then has the value.
  assign raw_wait =
    (uses_a & ~a_zero & ((wr_e & (rdE == rs1D)) | (regWriteM & (rdM == rs1D)) | (regWriteW & (rdW == rs1D)))) |
    (uses_b & ~b_zero & ((wr_e & (rdE == rs2D)) | (regWriteM & (rdM == rs2D)) | (regWriteW & (rdW == rs2D))));

  assign op_a = a_zero ? '0 : rd1D;
  assign op_b = b_zero ? '0 : rd2D;

  assign unused_fwd = ^{aluOutE, aluOutM, resultW};
`endif

  assign hazard = load_use | raw_wait;
  assign stallD = hazard | stallE;

  logic issue;
  logic illegal_next;

  assign issue        = validD & legal & ~hazard & ~flushE;
  assign illegal_next = validD & ~legal & ~hazard & ~flushE;

  // Flush overrides a downstream hold; anything that does not issue leaves a bubble behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      validE      <= 1'b0;
      regWriteE   <= 1'b0;
      memReadE    <= 1'b0;
      illegalE    <= 1'b0;
      ALUControlE <= ADD_OP;
      srcAE       <= '0;
      srcBE       <= '0;
      rdE         <= '0;
    end else if (flushE || !stallE) begin
      validE      <= issue;
      regWriteE   <= issue & (rdD != '0);
      memReadE    <= issue & is_load;
      illegalE    <= illegal_next;
      ALUControlE <= issue ? alu_ctrl : ADD_OP;
      srcAE       <= issue ? op_a : '0;
      srcBE       <= issue ? (use_imm ? immD : op_b) : '0;
      rdE         <= issue ? rdD : '0;
    end
  end

endmodule
